// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with a start/done handshake. Logic ops, add/sub
// and compare finish in one cycle; multiply and non-zero shifts iterate one
// bit per clock while busy is raised.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] FULLCOUNT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] ONE       = (SHW+1)'(1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t state;
    state_t nextstate;

    // count is one bit wider than the shift field so it can hold WIDTH itself
    logic [SHW:0]     count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shval;
    logic             shleft;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] quick;
    logic [WIDTH-1:0] mulsum;
    logic [WIDTH-1:0] shnext;
    logic             accept;
    logic             isshift;
    logic             lastcycle;

    assign shamt     = b[SHW-1:0];
    assign accept    = (state == IDLE) && start;
    assign isshift   = (sel == OP_SLL) || (sel == OP_SRL);
    assign lastcycle = (count == ONE);
    assign mulsum    = acc + (mplier[0] ? mcand : '0);
    assign shnext    = shleft ? (shval << 1) : (shval >> 1);
    assign busy      = (state != IDLE);

    // Single-cycle result straight from the live operands; a zero-length shift is a pass-through of a
    always_comb begin
        quick = '0;
        case (sel)
            OP_AND:  quick = a & b;
            OP_OR:   quick = a | b;
            OP_ADD:  quick = a + b;
            OP_SUB:  quick = a - b;
            OP_SLT:  quick[0] = ($signed(a) < $signed(b));
            default: quick = a;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextstate;
        end
    end

    // Next-state: leave IDLE only for multiply or a non-zero shift, return on the final iteration
    always_comb begin
        nextstate = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (sel == OP_MUL) begin
                        nextstate = MUL;
                    end else if (isshift && (shamt != '0)) begin
                        nextstate = SHIFT;
                    end
                end
            end
            MUL, SHIFT: begin
                if (lastcycle) begin
                    nextstate = IDLE;
                end
            end
            default: nextstate = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate while busy, publish out/zero/done only on completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out    <= '0;
            zero   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            shval  <= '0;
            shleft <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (sel == OP_MUL) begin
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            count  <= FULLCOUNT;
                        end else if (isshift && (shamt != '0)) begin
                            shval  <= a;
                            shleft <= (sel == OP_SLL);
                            count  <= {1'b0, shamt};
                        end else begin
                            out  <= quick;
                            zero <= (quick == '0);
                            done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= mulsum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - ONE;
                    if (lastcycle) begin
                        out  <= mulsum;
                        zero <= (mulsum == '0);
                        done <= 1'b1;
                    end
                end
                SHIFT: begin
                    shval <= shnext;
                    count <= count - ONE;
                    if (lastcycle) begin
                        out  <= shnext;
                        zero <= (shnext == '0);
                        done <= 1'b1;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq. Expected results are queued when
// an operation is issued; a monitor pops and compares on every done pulse.
module tb_alu_seq;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        zero;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] qout[$];
    logic        qzero[$];
    int          qcyc[$];
    string       qname[$];

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .sel(sel),
        .a(a),
        .b(b),
        .out(out),
        .zero(zero),
        .busy(busy),
        .done(done)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Edge counter used to timestamp accepts and completions
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input string name, input logic [31:0] eout, input logic ez, input int ecyc);
        qout.push_back(eout);
        qzero.push_back(ez);
        qcyc.push_back(ecyc);
        qname.push_back(name);
    endtask

    task automatic flushExpect();
        qout.delete();
        qzero.delete();
        qcyc.delete();
        qname.delete();
    endtask

    // Called one cycle after the accept edge; counts busy cycles until the scoreboard drains
    task automatic waitDrain(output int busycnt);
        int guard;
        busycnt = busy ? 1 : 0;
        guard = 0;
        while (qout.size() != 0 && guard < 100) begin
            @(negedge clk);
            #1;
            if (busy) busycnt++;
            guard++;
        end
        if (qout.size() != 0) begin
            checkOutput("drain_timeout", qout.size(), 0);
            flushExpect();
        end
    endtask

    task automatic applyStimulus(input string name, input logic [2:0] s, input logic [31:0] aa,
                                 input logic [31:0] bb, input logic [31:0] eout, input logic ez,
                                 input int lat, input int ebusy);
        int bc;
        @(negedge clk);
        #1;
        sel = s;
        a = aa;
        b = bb;
        start = 1'b1;
        pushExpect(name, eout, ez, cyc + lat);
        @(negedge clk);
        #1;
        start = 1'b0;
        waitDrain(bc);
        if (ebusy >= 0) checkOutput({name, "_busycycles"}, bc, ebusy);
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checkOutput("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
            if (done === 1'b1) begin
                if (qout.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
                end else begin
                    checkOutput({qname[0], "_out"}, out, qout[0]);
                    checkOutput({qname[0], "_zero"}, {31'b0, zero}, {31'b0, qzero[0]});
                    checkOutput({qname[0], "_cycle"}, cyc, qcyc[0]);
                    void'(qout.pop_front());
                    void'(qzero.pop_front());
                    void'(qcyc.pop_front());
                    void'(qname.pop_front());
                end
            end
        end
    end

    initial begin
        int bc;
        int k;
        reset = 1'b1;
        start = 1'b0;
        sel = OP_AND;
        a = '0;
        b = '0;

        @(negedge clk);
        checkOutput("reset_out", out, 32'd0);
        checkOutput("reset_zero", {31'b0, zero}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        #1;
        reset = 1'b0;

        // Reset asserted mid-cycle while done is high clears everything before any edge
        @(negedge clk);
        #1;
        sel = OP_ADD; a = 32'd7; b = 32'd1; start = 1'b1;
        pushExpect("add_pre_reset", 32'd8, 1'b0, cyc + 1);
        @(posedge clk);
        #2;
        start = 1'b0;
        checkOutput("pre_reset_done", {31'b0, done}, 32'd1);
        checkOutput("pre_reset_out", out, 32'd8);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_out", out, 32'd0);
        checkOutput("async_reset_zero", {31'b0, zero}, 32'd0);
        checkOutput("async_reset_done", {31'b0, done}, 32'd0);
        checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
        flushExpect();
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Single-cycle operations
        applyStimulus("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 0);
        applyStimulus("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 0);
        applyStimulus("slt_true", OP_SLT, 32'hFFFF_FFFD, 32'd2, 32'd1, 1'b0, 1, 0);
        applyStimulus("slt_false", OP_SLT, 32'd2, 32'hFFFF_FFFD, 32'd0, 1'b1, 1, 0);
        applyStimulus("and", OP_AND, 32'hF0, 32'h0F, 32'd0, 1'b1, 1, 0);
        applyStimulus("or", OP_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1, 0);

        // Multiply
        applyStimulus("mul_basic", OP_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, 33, 32);
        applyStimulus("mul_allones", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32);
        applyStimulus("mul_signed", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 32);
        applyStimulus("mul_zero", OP_MUL, 32'h1234_5678, 32'd0, 32'd0, 1'b1, 33, 32);

        // Shifts
        applyStimulus("sll4", OP_SLL, 32'h1, 32'h24, 32'h10, 1'b0, 5, 4);
        applyStimulus("srl31", OP_SRL, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 32, 31);
        applyStimulus("sll0", OP_SLL, 32'hABCD, 32'h20, 32'hABCD, 1'b0, 1, 0);
        applyStimulus("srl8_zero", OP_SRL, 32'h0F, 32'd8, 32'd0, 1'b1, 9, 8);

        // start pulsed and inputs changed while a multiply is busy
        @(negedge clk);
        #1;
        sel = OP_MUL; a = 32'd3; b = 32'd4; start = 1'b1;
        pushExpect("mul_ignore_start", 32'd12, 1'b0, cyc + 33);
        @(negedge clk);
        #1;
        start = 1'b0; sel = OP_ADD; a = 32'hDEAD; b = 32'hBEEF;
        repeat (5) @(negedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0; a = 32'd9; b = 32'd9;
        waitDrain(bc);
        repeat (5) @(negedge clk);

        // Back-to-back single-cycle ops with start held high
        @(negedge clk);
        #1;
        sel = OP_ADD; a = 32'd1; b = 32'd2; start = 1'b1;
        pushExpect("b2b_add", 32'd3, 1'b0, cyc + 1);
        @(negedge clk);
        #1;
        sel = OP_SUB; a = 32'd10; b = 32'd3;
        pushExpect("b2b_sub", 32'd7, 1'b0, cyc + 1);
        @(negedge clk);
        #1;
        sel = OP_SLT; a = 32'd5; b = 32'd9;
        pushExpect("b2b_slt", 32'd1, 1'b0, cyc + 1);
        @(negedge clk);
        #1;
        start = 1'b0;
        waitDrain(bc);

        // start held through the multiply's done cycle: the next op is accepted there
        @(negedge clk);
        #1;
        sel = OP_MUL; a = 32'd6; b = 32'd7; start = 1'b1;
        k = cyc;
        pushExpect("hold_mul", 32'd42, 1'b0, k + 33);
        @(negedge clk);
        #1;
        sel = OP_ADD; a = 32'd100; b = 32'd1;
        pushExpect("hold_add", 32'd101, 1'b0, k + 34);
        while (cyc < k + 34) begin
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        waitDrain(bc);
        repeat (3) @(negedge clk);

        // Reset at edge T+10 of a multiply discards it
        @(negedge clk);
        #1;
        sel = OP_MUL; a = 32'h1234; b = 32'h10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        checkOutput("mid_mul_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_mul_reset_out", out, 32'd0);
        checkOutput("mid_mul_reset_zero", {31'b0, zero}, 32'd0);
        checkOutput("mid_mul_reset_done", {31'b0, done}, 32'd0);
        checkOutput("mid_mul_reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        applyStimulus("add_after_reset", OP_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1, 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", qout.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
